// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive path.
// Holds the clock and baud constants that the baud-rate generator and the
// receive framer must agree on, the receive FSM state encoding and the
// default frame/synchroniser parameters.
package uart_rx_frame_pkg;

    localparam int CLK_FREQ_HZ     = 1_000_000;
    localparam int BAUD_RATE       = 62_500;
    localparam int BAUD_DIV        = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_HALF       = BAUD_DIV / 2;

    localparam int DATA_BITS_DEF   = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser and falling-edge detector for the serial line.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   rxd   - raw serial input, asynchronous to clk, idle high
//   rxd_s - synchronised line level
//   fall  - high for one cycle when the synchronised line goes 1 -> 0
module uart_rx_sync
    import uart_rx_frame_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Reset to the idle level: a line already low at reset release then
    // looks like a fresh falling edge and starts a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];
    assign fall  = hist_q & ~rxd_s;

endmodule

// File: rtl/uart_rx_frame.sv
// Receive framer for one 8N1 frame, LSB first.
// Detects the start edge, holds bps_start high so the baud-rate generator
// issues mid-bit bps_hf strobes, shifts the data bits in and publishes the
// byte with a one-cycle rx_done strobe (frame_err alongside if stop bit = 0).
// Ports:
//   clk, rst   - system clock, asynchronous active-low reset
//   rxd        - raw serial line
//   bps_hf     - mid-bit sample strobe from the baud-rate generator
//   bps_start  - run request to the baud-rate generator, high for the frame
//   rx_data    - last received byte, held until the next completed frame
//   rx_done    - one-cycle strobe, rx_data valid in the same cycle
//   frame_err  - one-cycle strobe with rx_done when the stop bit sampled 0
//   rx_busy    - high whenever the FSM is not idle
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge, strobes ignored
// RX_START | waiting for the start-bit sample, 1 means false start
// RX_DATA  | shifting in DATA_BITS samples
// RX_STOP  | waiting for the stop-bit sample, then publish
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 bps_hf,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rxd_s, fall;
    logic                 cnt_clr, shift_en, load_en;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .rxd_s(rxd_s),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RX_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        load_en  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_clr = 1'b1;
                end
            end
            RX_START: begin
                if (bps_hf) state_d = rxd_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (bps_hf) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == CNT_LAST) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bps_hf) begin
                    load_en = 1'b1;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Publish and error flag are registered, so they land in the first idle
    // cycle, where a new start edge may already be accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= load_en;
            frame_err <= load_en & ~rxd_s;
            if (cnt_clr)       bit_cnt_q <= '0;
            else if (shift_en) bit_cnt_q <= bit_cnt_q + 1'b1;
            if (shift_en) shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            if (load_en)  rx_data <= shift_q;
        end
    end

    assign bps_start = (state_q != RX_IDLE);
    assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;
    import uart_rx_frame_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       bps_hf;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    logic       stray_hf;
    logic       model_hf;
    int         gen_cnt;
    int         hf_cnt = 0;

    int         n_vec = 0;
    int         n_err = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic [7:0] exp_rx;

    uart_rx_frame dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .bps_hf   (bps_hf),
        .bps_start(bps_start),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud-rate generator model: counts only while bps_start is high and
    // strobes in the middle of each bit period.
    always @(posedge clk or negedge rst) begin
        if (!rst)                      gen_cnt <= 0;
        else if (!bps_start)           gen_cnt <= 0;
        else if (gen_cnt == BAUD_DIV-1) gen_cnt <= 0;
        else                           gen_cnt <= gen_cnt + 1;
    end
    assign model_hf = bps_start && (gen_cnt == BAUD_HALF);
    assign bps_hf   = model_hf | stray_hf;

    always @(posedge clk) if (bps_hf && bps_start) hf_cnt <= hf_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rx_done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rx_done", {31'd0, rx_done}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, mon_e[7:0]});
                chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e[8]});
                chk("bps_start_at_done", {31'd0, bps_start}, 32'd0);
                chk("rx_busy_at_done", {31'd0, rx_busy}, 32'd0);
            end
        end else if (frame_err) begin
            chk("frame_err_alone", {31'd0, frame_err}, 32'd0);
        end
    end

    // Reference: a frame yields its byte, and an error exactly when stop = 0.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input bit push);
        if (push) exp_q.push_back({~stop_b, d});
        rxd = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        rxd = stop_b;
        repeat (BAUD_DIV) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bps_start"}, {31'd0, bps_start}, 32'd0);
        chk({tag, "_rx_busy"},   {31'd0, rx_busy},   32'd0);
        chk({tag, "_rx_data"},   {24'd0, rx_data},   32'd0);
        chk({tag, "_rx_done"},   {31'd0, rx_done},   32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] d;
        logic       st;
        rst      = 1'b0;
        rxd      = 1'b1;
        stray_hf = 1'b0;
        exp_rx   = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Stray strobes while idle
        for (int i = 0; i < 4; i++) begin
            stray_hf = 1'b1;
            @(negedge clk);
            stray_hf = 1'b0;
            @(negedge clk);
            chk("stray_bps_start", {31'd0, bps_start}, 32'd0);
            chk("stray_rx_busy", {31'd0, rx_busy}, 32'd0);
        end
        chk("stray_rx_data", {24'd0, rx_data}, {24'd0, exp_rx});

        // Nominal frame
        base = hf_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        exp_rx = 8'hA5;
        wait_drain();
        chk("nominal_strobes", hf_cnt - base, 32'd10);
        chk("nominal_bps_start_low", {31'd0, bps_start}, 32'd0);

        // Back-to-back extremes, no idle gap
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        exp_rx = 8'hFF;
        wait_drain();
        chk("b2b_rx_data", {24'd0, rx_data}, {24'd0, exp_rx});

        // Glitch start
        repeat (5) @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy_during", {31'd0, rx_busy}, 32'd1);
        repeat (30) @(negedge clk);
        chk("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
        chk("glitch_bps_start", {31'd0, bps_start}, 32'd0);
        chk("glitch_rx_data", {24'd0, rx_data}, {24'd0, exp_rx});

        // Framing error then stuck-low line
        send_frame(8'h3C, 1'b0, 1'b1);
        exp_rx = 8'h3C;
        repeat (2*BAUD_DIV) @(negedge clk);
        chk("break_no_retrigger", {31'd0, rx_busy}, 32'd0);
        rxd = 1'b1;
        repeat (BAUD_DIV) @(negedge clk);
        chk("break_idle", {31'd0, rx_busy}, 32'd0);
        wait_drain();

        // Reset mid-frame: start bit plus data bits 0..3 of 0x96
        d = 8'h96;
        rxd = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        chk("midframe_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b1, 1'b1);
        exp_rx = 8'h5A;
        wait_drain();
        chk("post_reset_rx_data", {24'd0, rx_data}, 32'h5A);

        // Randomised frames
        for (int n = 0; n < 10; n++) begin
            d  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) != 0);
            send_frame(d, st, 1'b1);
            exp_rx = d;
            rxd = 1'b1;
            if (!st) repeat (3 + $urandom_range(0, 5)) @(negedge clk);
            else     repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_drain();
        chk("random_last_rx_data", {24'd0, rx_data}, {24'd0, exp_rx});
        repeat (20) @(negedge clk);
        chk("final_idle", {31'd0, rx_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
